spi_master_multi: RTL
=====================

Name: spi_master_multi

Overview:
Single-clock, parametrised SPI master. Successor to the dual-clock spi_master/spi_master_phy pair, adding:
- configurable CPOL/CPHA, bit order, and multiple slave selects.
- back-to-back word streaming with ss held low.
- an RX overflow flag.

Sits between a bus peripheral and external SPI pins, with internal TX/RX FIFOs (lib/fifo.v, same clock on both sides).

Parameters:
DATABITSIZE, 8, bits per SPI word (>=2)
BUFFERSIZE, 4, depth of each of TX and RX FIFO (power of 2, >=2)
SCLKDIVIDELIMIT, 256, number of selectable sclk dividers
SSCOUNT, 1, number of slave-select outputs (>=1)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
sclk_o  out  1  SPI clock
mosi_o  out  1  SPI data out
miso_i  in  1  SPI data in
ss_o  out  SSCOUNT  slave selects, active low
cpol_i  in  1  clock polarity
cpha_i  in  1  clock phase
lsbfirst_i  in  1  1 = LSB shifted first
sssel_i  in  max(clog2(SSCOUNT),1)  slave index
sclkdivide_i  in  clog2(SCLKDIVIDELIMIT)  sclk half-period = sclkdivide_i+1 clk_i cycles
txwrite_i  in  1  push txdata_i
txdata_i  in  DATABITSIZE  word to send
txusage_o  out  clog2(BUFFERSIZE)+1  TX entries
txfull_o  out  1  TX FIFO full
rxread_i  in  1  pop RX FIFO
rxdata_o  out  DATABITSIZE  head of RX FIFO
rxusage_o  out  clog2(BUFFERSIZE)+1  RX entries
rxempty_o  out  1  RX FIFO empty
rxoverflow_o  out  1  one-cycle pulse: received word dropped
busy_o  out  1  FSM not IDLE

Behaviour:
Reset (rst_ni low, async):
- FIFOs emptied; FSM = IDLE.
- ss_o all ones; sclk_o = 0; mosi_o = 0; busy_o = 0; rxoverflow_o = 0.
- Reset mid-word aborts immediately; ss_o deasserts asynchronously; no partial word reaches RX FIFO.

Config latching:
- cpol/cpha/lsbfirst/sssel/sclkdivide are latched on the IDLE->SETUP transition.
- In IDLE, sclk_o tracks cpol_i.

FSM:
- IDLE: leave when txempty=0. Pop TX word into shift register, latch config -> SETUP.
- SETUP: ss_o[sssel] low; if cpha=0, first bit driven on mosi_o. Wait one half-period -> XFER.
- XFER: 2*DATABITSIZE sclk edges, each one half-period apart.
  - cpha=0: sample miso on leading edge, shift mosi on trailing edge.
  - cpha=1: shift on leading edge, sample on trailing edge.
  - After the last edge -> HOLD.
- HOLD: one half-period. Received word written to RX FIFO on entry.
  - If TX non-empty and the live config equals the latched config: pop next word -> XFER. ss stays low, no extra SETUP.
  - Otherwise -> GAP.
- GAP: ss_o all high for one half-period -> IDLE.

Bit order: MSB first unless lsbfirst latched 1.

Timing:
- Write in cycle N -> busy_o=1 and ss_o low after edge N+2.
- Divider counter reloads on every state change.

Boundary cases:
- TX write while full: ignored, no corruption.
- RX read while empty: ignored; rxdata_o holds.
- RX FIFO full when a word completes: word dropped; rxoverflow_o=1 for exactly one cycle; transfer continues.
- Simultaneous TX write and FSM pop: both honoured; usage unchanged.
- Simultaneous RX read and FSM write: both honoured.
- sssel_i >= SSCOUNT: clamped to SSCOUNT-1 when latched.

Optional Feature:
SPI_MASTER_LOOPBACK_EN:
- Defined: adds input port loopback_i (1 bit), latched with the other config. When latched 1, the RX shifter samples mosi_o internally instead of miso_i; pins otherwise behave identically.
- Undefined: the port is absent and miso_i is always sampled.

Test Plan:
1. Mode 0, sclkdivide=0, MSB first, write 0xA5, miso drives 0x3C -> mosi bits 1,0,1,0,0,1,0,1; 8 sclk periods of 2 clk each; rxdata_o=0x3C; ss_o low for exactly 18 half-periods (SETUP + 16 edges + HOLD).
2. Mode 3 (cpol=1, cpha=1), lsbfirst=1, write 0x01 -> sclk idles high; first mosi bit 1 after first falling edge; loopback/miso 0x80 yields rxdata_o=0x80.
3. Write 3 words while busy, config constant -> ss_o stays low continuously across all 3 words; rxusage_o reaches 3.
4. Fill RX (BUFFERSIZE=4) without reading, send 5th word -> rxoverflow_o single-cycle pulse; rxusage_o stays 4; first 4 words are intact.
5. SSCOUNT=4, change sssel_i 1->2 between queued words -> ss_o[1] deasserts, GAP half-period, then ss_o[2] asserts; other ss bits never toggle.
6. Assert rst_ni low at bit 4 of a word -> ss_o=all high and sclk_o=0 immediately; after release busy_o=0 and txusage_o=rxusage_o=0.

Source files
------------

// File: rtl/spi_master_multi.sv
// spi_master_multi: single-clock SPI master with CPOL/CPHA, bit order,
// multiple slave selects, back-to-back streaming and TX/RX FIFOs.
// Optional macro SPI_MASTER_LOOPBACK_EN adds loopback_i (RX samples mosi_o).
`timescale 1ns/1ps

module spi_master_multi_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [AW:0]   usage,
   output logic          full,
   output logic          empty
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic          do_push, do_pop;

   assign empty   = (usage == '0);
   assign full    = (usage == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // a full FIFO still accepts a write when the same cycle frees a slot
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rp];

   // storage array, no reset needed
   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= wdata;
   end

   // pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         usage <= '0;
      end else begin
         if (do_push) wp <= wp + AW'(1);
         if (do_pop)  rp <= rp + AW'(1);
         usage <= usage + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

module spi_master_multi #(
   parameter int DATABITSIZE     = 8,
   parameter int BUFFERSIZE      = 4,
   parameter int SCLKDIVIDELIMIT = 256,
   parameter int SSCOUNT         = 1,
   localparam int SW = (SSCOUNT > 1) ? $clog2(SSCOUNT) : 1,
   localparam int DW = $clog2(SCLKDIVIDELIMIT),
   localparam int UW = $clog2(BUFFERSIZE) + 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   output logic                   sclk_o,
   output logic                   mosi_o,
   input  logic                   miso_i,
`ifdef SPI_MASTER_LOOPBACK_EN
   input  logic                   loopback_i,
`endif
   output logic [SSCOUNT-1:0]     ss_o,
   input  logic                   cpol_i,
   input  logic                   cpha_i,
   input  logic                   lsbfirst_i,
   input  logic [SW-1:0]          sssel_i,
   input  logic [DW-1:0]          sclkdivide_i,
   input  logic                   txwrite_i,
   input  logic [DATABITSIZE-1:0] txdata_i,
   output logic [UW-1:0]          txusage_o,
   output logic                   txfull_o,
   input  logic                   rxread_i,
   output logic [DATABITSIZE-1:0] rxdata_o,
   output logic [UW-1:0]          rxusage_o,
   output logic                   rxempty_o,
   output logic                   rxoverflow_o,
   output logic                   busy_o
);
   localparam int BW = $clog2(DATABITSIZE);
   localparam int EW = BW + 1;

   typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

   state_t                 state;
   logic [DW-1:0]          cnt, div_q;
   logic [EW-1:0]          ecnt;
   logic [DATABITSIZE-1:0] tx_sh, rx_sh, tx_head;
   logic                   cpol_q, cpha_q, lsb_q;
   logic [SW-1:0]          sel_q, sel_live;
   logic                   tx_empty, tx_pop, rx_push, rx_full;
   logic                   half_done, cfg_match, rx_in, lb_ok;
   logic                   smp, last;
   logic [BW-1:0]          cur_bit, drv_bit;

   // bit index within a word -> register position for the selected order
   function automatic logic [BW-1:0] bpos(input logic lsb, input logic [BW-1:0] b);
      return lsb ? b : BW'(DATABITSIZE-1) - b;
   endfunction

   assign sel_live  = (32'(sssel_i) >= 32'(SSCOUNT)) ? SW'(SSCOUNT-1) : sssel_i;
   assign half_done = (cnt == '0);
   assign cur_bit   = ecnt[EW-1:1];
   assign last      = (ecnt == EW'(2*DATABITSIZE-1));
   // even edge count = leading edge; cpha0 samples leading, cpha1 trailing
   assign smp       = (ecnt[0] == cpha_q);
   assign drv_bit   = cpha_q ? cur_bit : cur_bit + BW'(1);

`ifdef SPI_MASTER_LOOPBACK_EN
   logic lb_q;
   assign rx_in = lb_q ? mosi_o : miso_i;
   assign lb_ok = (loopback_i == lb_q);

   // loopback select is latched together with the rest of the config
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                      lb_q <= 1'b0;
      else if (state == IDLE && tx_pop) lb_q <= loopback_i;
   end
`else
   assign rx_in = miso_i;
   assign lb_ok = 1'b1;
`endif

   assign cfg_match = (cpol_i == cpol_q) && (cpha_i == cpha_q) && (lsbfirst_i == lsb_q) &&
                      (sel_live == sel_q) && (sclkdivide_i == div_q) && lb_ok;
   assign tx_pop    = !tx_empty && ((state == IDLE) ||
                      (state == HOLD && half_done && cfg_match));

   // transfer FSM with registered pin outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state  <= IDLE;
         ss_o   <= '1;
         sclk_o <= 1'b0;
         mosi_o <= 1'b0;
         busy_o <= 1'b0;
         cnt    <= '0;
         ecnt   <= '0;
         tx_sh  <= '0;
         rx_sh  <= '0;
         cpol_q <= 1'b0;
         cpha_q <= 1'b0;
         lsb_q  <= 1'b0;
         sel_q  <= '0;
         div_q  <= '0;
         rx_push <= 1'b0;
      end else begin
         rx_push <= 1'b0;
         case (state)
            IDLE: begin
               sclk_o <= cpol_i;
               if (tx_pop) begin
                  tx_sh  <= tx_head;
                  cpol_q <= cpol_i;
                  cpha_q <= cpha_i;
                  lsb_q  <= lsbfirst_i;
                  sel_q  <= sel_live;
                  div_q  <= sclkdivide_i;
                  cnt    <= sclkdivide_i;
                  ss_o   <= ~(SSCOUNT'(1) << sel_live);
                  busy_o <= 1'b1;
                  state  <= SETUP;
                  if (!cpha_i) mosi_o <= tx_head[bpos(lsbfirst_i, BW'(0))];
               end
            end
            SETUP: begin
               if (half_done) begin
                  state <= XFER;
                  cnt   <= div_q;
                  ecnt  <= '0;
               end else cnt <= cnt - DW'(1);
            end
            XFER: begin
               if (half_done) begin
                  sclk_o <= ~sclk_o;
                  cnt    <= div_q;
                  ecnt   <= ecnt + EW'(1);
                  if (smp)        rx_sh[bpos(lsb_q, cur_bit)] <= rx_in;
                  else if (!last) mosi_o <= tx_sh[bpos(lsb_q, drv_bit)];
                  if (last) begin
                     state   <= HOLD;
                     rx_push <= 1'b1;
                  end
               end else cnt <= cnt - DW'(1);
            end
            HOLD: begin
               if (half_done) begin
                  cnt  <= div_q;
                  ecnt <= '0;
                  if (tx_pop) begin
                     tx_sh <= tx_head;
                     state <= XFER;
                     if (!cpha_q) mosi_o <= tx_head[bpos(lsb_q, BW'(0))];
                  end else begin
                     ss_o  <= '1;
                     state <= GAP;
                  end
               end else cnt <= cnt - DW'(1);
            end
            GAP: begin
               if (half_done) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end else cnt <= cnt - DW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

   // one-cycle pulse when a completed word finds the RX FIFO full
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rxoverflow_o <= 1'b0;
      else         rxoverflow_o <= rx_push && rx_full && !rxread_i;
   end

   spi_master_multi_fifo #(.W(DATABITSIZE), .DEPTH(BUFFERSIZE)) u_txf (
      .clk(clk_i), .rst_n(rst_ni), .push(txwrite_i), .pop(tx_pop), .wdata(txdata_i),
      .rdata(tx_head), .usage(txusage_o), .full(txfull_o), .empty(tx_empty)
   );

   spi_master_multi_fifo #(.W(DATABITSIZE), .DEPTH(BUFFERSIZE)) u_rxf (
      .clk(clk_i), .rst_n(rst_ni), .push(rx_push), .pop(rxread_i), .wdata(rx_sh),
      .rdata(rxdata_o), .usage(rxusage_o), .full(rx_full), .empty(rxempty_o)
   );
endmodule
